hex_load_ctrl: RTL and testbench

//  Sequences an Intel-HEX download through the HEXBIN converter: accepts ASCII chars from a

---
 rtl/hex_load_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_hex_load_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_load_ctrl.sv
// hex_load_ctrl: sequences an Intel-HEX download through a HEXBIN converter.
//   Accepts ASCII chars on a valid/ready byte stream and paces them into the converter
//   as EN strobes. It tracks record framing to find the EOF record and arbitrates the
//   shared memory write port between the converter (while loading) and the CPU (after
//   a successful load). The CPU is held in reset until a load completes cleanly.
// Ports:
//   clk, clr_n                 clock, synchronous active-low reset
//   start                      begin load (honoured in idle/done/fail)
//   rx_data, rx_valid/rx_ready byte source handshake
//   cnv_di, cnv_en, cnv_clr    converter char, strobe, clear
//   cnv_ab/db/we/err           converter write request and error flag
//   cpu_ab/db/we               CPU write request
//   mem_ab/db/we               shared memory write port
//   cpu_hold, busy, done       status
//   err_code                   00 none, 01 converter error, 10 timeout
//   byte_cnt                   converter writes in current load (saturating)
module hex_load_ctrl #(
  parameter int unsigned EN_WIDTH = 1,
  parameter int unsigned CHAR_GAP = 1,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  cnv_di,
  output logic        cnv_en,
  output logic        cnv_clr,
  input  logic [15:0] cnv_ab,
  input  logic [7:0]  cnv_db,
  input  logic        cnv_we,
  input  logic        cnv_err,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_db,
  input  logic        cpu_we,
  output logic [15:0] mem_ab,
  output logic [7:0]  mem_db,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [15:0] byte_cnt
);

  typedef enum logic [2:0] {
    StIdle, StClear, StWaitChar, StStrobe, StGap, StFlush, StDone, StFail
  } state_e;

  localparam logic [15:0] EnLast    = 16'(EN_WIDTH - 1);
  localparam logic [15:0] GapLast   = 16'(CHAR_GAP - 1);
  localparam logic [15:0] FlushLast = 16'(CHAR_GAP + 1);
  localparam logic [15:0] ToLast    = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  di_q, di_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] bytes_q, bytes_d;
  logic [9:0]  dig_q, dig_d;
  logic        armed_q, armed_d;
  logic        eof_q, eof_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  type_q, type_d;

  logic        xfer, restart, owner_cpu, is_hex;
  logic [3:0]  nib;
  logic [9:0]  dig_inc;

  assign rx_ready  = (state_q == StWaitChar);
  assign cnv_en    = (state_q == StStrobe);
  // Idle is only reachable through reset, where the converter is held clear too.
  assign cnv_clr   = (state_q == StIdle) || (state_q == StClear);
  assign busy      = (state_q == StClear) || (state_q == StWaitChar) || (state_q == StStrobe) ||
                     (state_q == StGap) || (state_q == StFlush);
  assign done      = (state_q == StDone);
  assign cpu_hold  = (state_q != StDone);
  assign owner_cpu = (state_q == StIdle) || (state_q == StDone);
  assign cnv_di    = di_q;
  assign err_code  = err_q;
  assign byte_cnt  = bytes_q;

  assign xfer    = rx_valid && rx_ready;
  assign restart = start && ((state_q == StIdle) || (state_q == StDone) || (state_q == StFail));
  assign dig_inc = dig_q + 10'd1;

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end
  end

  // Sequencer: one shared counter times clear, strobe, gap, flush and the char timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          state_d = StClear;
          cnt_d   = '0;
          err_d   = 2'b00;
        end
      end
      StClear: begin
        if (cnt_q == 16'd1) begin
          state_d = StWaitChar;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitChar: begin
        if (cnv_err) begin
          state_d = StFail;
          err_d   = 2'b01;
        end else if (xfer) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end else if (cnt_q == ToLast) begin
          state_d = StFail;
          err_d   = 2'b10;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStrobe: begin
        if (cnv_err) begin
          state_d = StFail;
          err_d   = 2'b01;
        end else if (cnt_q == EnLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StGap: begin
        if (cnv_err) begin
          state_d = StFail;
          err_d   = 2'b01;
        end else if (cnt_q == GapLast) begin
          state_d = eof_q ? StFlush : StWaitChar;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StFlush: begin
        if (cnv_err) begin
          state_d = StFail;
          err_d   = 2'b01;
        end else if (cnt_q == FlushLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Record framing tracker; the record closes once its last checksum digit arrives.
  always_comb begin
    di_d    = di_q;
    dig_d   = dig_q;
    armed_d = armed_q;
    len_d   = len_q;
    type_d  = type_q;
    eof_d   = eof_q;
    bytes_d = bytes_q;
    if (restart) begin
      dig_d   = '0;
      armed_d = 1'b0;
      len_d   = '0;
      type_d  = '0;
      eof_d   = 1'b0;
      bytes_d = '0;
    end else begin
      if (busy && cnv_we && (bytes_q != 16'hFFFF)) begin
        bytes_d = bytes_q + 16'd1;
      end
      if (xfer) begin
        di_d = rx_data;
        if (rx_data == 8'h3A) begin
          dig_d   = '0;
          armed_d = 1'b1;
        end else if (is_hex && armed_q) begin
          dig_d = dig_inc;
          case (dig_inc)
            10'd1:   len_d[7:4]  = nib;
            10'd2:   len_d[3:0]  = nib;
            10'd7:   type_d[7:4] = nib;
            10'd8:   type_d[3:0] = nib;
            default: ;
          endcase
          if (dig_inc == ({1'b0, len_q, 1'b0} + 10'd10)) begin
            armed_d = 1'b0;
            if (type_q == 8'h01) eof_d = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    if (owner_cpu) begin
      mem_ab = cpu_ab;
      mem_db = cpu_db;
      mem_we = cpu_we;
    end else begin
      mem_ab = cnv_ab;
      mem_db = cnv_db;
      mem_we = cnv_we && busy;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      di_q    <= '0;
      err_q   <= 2'b00;
      bytes_q <= '0;
      dig_q   <= '0;
      armed_q <= 1'b0;
      len_q   <= '0;
      type_q  <= '0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      di_q    <= di_d;
      err_q   <= err_d;
      bytes_q <= bytes_d;
      dig_q   <= dig_d;
      armed_q <= armed_d;
      len_q   <= len_d;
      type_q  <= type_d;
      eof_q   <= eof_d;
    end
  end

endmodule

// File: tb/tb_hex_load_ctrl.sv
// Testbench for hex_load_ctrl: a small behavioural converter model produces write
// strobes from the paced chars; memory-port arbitration is checked from a vector table.
module tb_hex_load_ctrl;

  logic        clk = 1'b0;
  logic        clr_n, start, rx_valid, cpu_we;
  logic [7:0]  rx_data, cpu_db;
  logic [15:0] cpu_ab;
  logic        rx_ready, cnv_en, cnv_clr, mem_we, cpu_hold, busy, done;
  logic [7:0]  cnv_di, mem_db;
  logic [15:0] mem_ab, byte_cnt;
  logic [1:0]  err_code;
  logic        cnv_err;

  // Converter side: model drives it unless a table vector overrides.
  logic        ovr, t_cnv_we;
  logic [15:0] t_cnv_ab;
  logic [7:0]  t_cnv_db;
  logic        m_we;
  logic [15:0] m_ab;
  logic [7:0]  m_db;
  logic        cnv_we;
  logic [15:0] cnv_ab;
  logic [7:0]  cnv_db;
  assign cnv_we = ovr ? t_cnv_we : m_we;
  assign cnv_ab = ovr ? t_cnv_ab : m_ab;
  assign cnv_db = ovr ? t_cnv_db : m_db;

  int errors = 0;
  int checks = 0;
  logic [23:0] wr_q[$];

  hex_load_ctrl #(.EN_WIDTH(2), .CHAR_GAP(3), .TIMEOUT(100)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .cnv_di(cnv_di), .cnv_en(cnv_en), .cnv_clr(cnv_clr),
    .cnv_ab(cnv_ab), .cnv_db(cnv_db), .cnv_we(cnv_we), .cnv_err(cnv_err),
    .cpu_ab(cpu_ab), .cpu_db(cpu_db), .cpu_we(cpu_we),
    .mem_ab(mem_ab), .mem_db(mem_db), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err_code(err_code), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          grp;  // 0 fail state, 1 done state, 2 busy
    logic        cpu_we;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_db;
    logic        cnv_we;
    logic [15:0] cnv_ab;
    logic [7:0]  cnv_db;
    logic        exp_we;
    logic [15:0] exp_ab;
    logic [7:0]  exp_db;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    rx_data  = c;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("send_ready_timeout", 32'(n), 32'd0);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("done_wait", 32'(done), 32'd1);
  endtask

  task automatic run_group(input int g);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].grp == g) begin
        cpu_we   = tbl[i].cpu_we;
        cpu_ab   = tbl[i].cpu_ab;
        cpu_db   = tbl[i].cpu_db;
        t_cnv_we = tbl[i].cnv_we;
        t_cnv_ab = tbl[i].cnv_ab;
        t_cnv_db = tbl[i].cnv_db;
        ovr      = 1'b1;
        #1;
        check($sformatf("mux_g%0d_v%0d", g, i), {7'd0, mem_we, mem_ab, mem_db},
              {7'd0, tbl[i].exp_we, tbl[i].exp_ab, tbl[i].exp_db});
      end
    end
    ovr    = 1'b0;
    cpu_we = 1'b0;
  endtask

  function automatic logic [4:0] hexnib(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39) return {1'b1, ch[3:0]};
    if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
      return {1'b1, ch[3:0] + 4'd9};
    return 5'd0;
  endfunction

  // Behavioural HEXBIN: one write per data byte at record address + index.
  logic        md_en_d = 1'b0, md_armed = 1'b0;
  int          md_dig = 0;
  logic [7:0]  md_byte = 8'd0, md_len = 8'd0;
  logic [15:0] md_addr = 16'd0;
  initial begin
    logic [7:0]  c;
    logic [4:0]  h;
    logic        en_now, clr_now, we_n;
    logic [15:0] ab_n;
    logic [7:0]  db_n;
    m_we = 1'b0;
    m_ab = 16'd0;
    m_db = 8'd0;
    forever begin
      @(posedge clk);
      c = cnv_di;
      en_now = cnv_en;
      clr_now = cnv_clr;
      we_n = 1'b0;
      ab_n = m_ab;
      db_n = m_db;
      h = hexnib(c);
      if (clr_now) begin
        md_armed = 1'b0;
        md_dig = 0;
      end else if (en_now && !md_en_d) begin
        if (c == 8'h3A) begin
          md_armed = 1'b1;
          md_dig = 0;
        end else if (md_armed && h[4]) begin
          md_dig++;
          md_byte = {md_byte[3:0], h[3:0]};
          if (md_dig == 2) md_len = md_byte;
          if (md_dig == 4) md_addr[15:8] = md_byte;
          if (md_dig == 6) md_addr[7:0] = md_byte;
          if (md_dig >= 10 && (md_dig % 2) == 0 && md_dig <= 8 + 2 * int'(md_len)) begin
            we_n = 1'b1;
            ab_n = md_addr + 16'((md_dig - 10) / 2);
            db_n = md_byte;
          end
          if (md_dig == 10 + 2 * int'(md_len)) md_armed = 1'b0;
        end
      end
      md_en_d = en_now;
      #1;
      m_we = we_n;
      m_ab = ab_n;
      m_db = db_n;
    end
  end

  always @(negedge clk) begin
    if (mem_we && !ovr) wr_q.push_back({mem_ab, mem_db});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rdy_bits, en_bits;
    int n;
    tbl[0] = '{0, 1'b1, 16'h1234, 8'h5A, 1'b1, 16'h00FF, 8'h3C, 1'b0, 16'h00FF, 8'h3C};
    tbl[1] = '{0, 1'b0, 16'h1234, 8'h5A, 1'b0, 16'h0100, 8'h00, 1'b0, 16'h0100, 8'h00};
    tbl[2] = '{1, 1'b1, 16'h1234, 8'h5A, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h1234, 8'h5A};
    tbl[3] = '{1, 1'b0, 16'h1234, 8'h5A, 1'b1, 16'h00FF, 8'h3C, 1'b0, 16'h1234, 8'h5A};
    tbl[4] = '{1, 1'b1, 16'hABCD, 8'hA5, 1'b1, 16'h00FF, 8'h3C, 1'b1, 16'hABCD, 8'hA5};
    tbl[5] = '{2, 1'b1, 16'h1234, 8'h5A, 1'b0, 16'h00FF, 8'h3C, 1'b0, 16'h00FF, 8'h3C};
    tbl[6] = '{2, 1'b0, 16'h1234, 8'h5A, 1'b1, 16'h0200, 8'h77, 1'b1, 16'h0200, 8'h77};

    clr_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cnv_err = 1'b0;
    cpu_we = 1'b0; cpu_ab = 16'h0; cpu_db = 8'h0;
    ovr = 1'b0; t_cnv_we = 1'b0; t_cnv_ab = 16'h0; t_cnv_db = 8'h0;

    // Reset
    tick();
    tick();
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_cnv_clr", 32'(cnv_clr), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check("rst_cnv_di", 32'(cnv_di), 32'd0);
    clr_n = 1'b1;
    tick();

    // Full load: one data record then EOF
    wr_q.delete();
    pulse_start();
    check("start_clear", 32'(cnv_clr), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    send_stream(":0200FF003C00C3\r\n:00000001FF");
    wait_done();
    check("load_busy", 32'(busy), 32'd0);
    check("load_cpu_hold", 32'(cpu_hold), 32'd0);
    check("load_byte_cnt", 32'(byte_cnt), 32'd2);
    check("load_err_code", 32'(err_code), 32'd0);
    check("load_writes", 32'(wr_q.size()), 32'd2);
    check("load_wr0", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFFFFFF, 32'h0000FF3C);
    check("load_wr1", (wr_q.size() > 1) ? 32'(wr_q[1]) : 32'hFFFFFFFF, 32'h00010000);

    // Pacing with rx_valid held high
    pulse_start();
    rx_data = 8'h41;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 12; i++) begin
      rdy_bits[i] = rx_ready;
      en_bits[i]  = cnv_en;
      tick();
    end
    rx_valid = 1'b0;
    check("pace_rx_ready", 32'(rdy_bits), 32'h041);
    check("pace_cnv_en", 32'(en_bits), 32'h186);
    check("pace_cnv_di", 32'(cnv_di), 32'h41);

    // Converter error mid-record
    send(8'h3A);
    send(8'h30);
    send(8'h32);
    check("err_in_strobe", 32'(cnv_en), 32'd1);
    cnv_err = 1'b1;
    tick();
    cnv_err = 1'b0;
    check("fail_err_code", 32'(err_code), 32'd1);
    check("fail_busy", 32'(busy), 32'd0);
    check("fail_done", 32'(done), 32'd0);
    check("fail_cpu_hold", 32'(cpu_hold), 32'd1);
    check("fail_rx_ready", 32'(rx_ready), 32'd0);
    run_group(0);

    // Restart clears the error, then times out with no chars
    pulse_start();
    check("restart_clr", 32'(cnv_clr), 32'd1);
    check("restart_err_code", 32'(err_code), 32'd0);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd102);
    check("timeout_err_code", 32'(err_code), 32'd2);

    // Reload from FAIL, then memory ownership
    pulse_start();
    send_stream(":0200FF003C00C3\r\n:00000001FF");
    wait_done();
    check("reload_byte_cnt", 32'(byte_cnt), 32'd2);
    run_group(1);
    pulse_start();
    run_group(2);

    // Reset while strobing
    send(8'h3A);
    check("rst2_in_strobe", 32'(cnv_en), 32'd1);
    clr_n = 1'b0;
    tick();
    check("rst2_cnv_en", 32'(cnv_en), 32'd0);
    check("rst2_cnv_clr", 32'(cnv_clr), 32'd1);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst2_cnv_di", 32'(cnv_di), 32'd0);
    check("rst2_byte_cnt", 32'(byte_cnt), 32'd0);
    clr_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
